// File: rtl/ray_gen.sv
// ray_gen: raster-order primary-ray generator; emits one Q15.16 camera ray per pixel on a valid/ready stream.
// Optional build macro RAYGEN_JITTER_EN adds LFSR-driven quarter-step sub-pixel jitter to the emitted direction.
module ray_gen #(
  parameter int unsigned XRES  = 640,
  parameter int unsigned YRES  = 480,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0][31:0]       cam_eye,
  input  logic [2:0][31:0]       cam_ll,
  input  logic [2:0][31:0]       cam_du,
  input  logic [2:0][31:0]       cam_dv,
  output logic                   ray_valid,
  input  logic                   ray_ready,
  output logic [2:0][31:0]       ray_origin,
  output logic [2:0][31:0]       ray_dir,
  output logic [CNT_W-1:0]       ray_px,
  output logic [CNT_W-1:0]       ray_py,
  output logic                   ray_last,
  output logic                   busy,
  output logic                   frame_done
);
  localparam logic [CNT_W-1:0] XMAX = CNT_W'(XRES - 1);
  localparam logic [CNT_W-1:0] YMAX = CNT_W'(YRES - 1);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t           state_q;
  logic             valid_q, busy_q, last_q, done_q;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [2:0][31:0] eye_q, du_q, dv_q;
  logic [2:0][31:0] dir_q, dir_d, row_q, row_d;
  logic             load, xfer, adv, last_d;

  // Next pixel position and centre direction; the last transfer leaves the counters untouched.
  always_comb begin
    load  = (state_q == IDLE) && start;
    xfer  = (state_q == EMIT) && valid_q && ray_ready;
    adv   = xfer && !last_q;
    x_d   = x_q;
    y_d   = y_q;
    dir_d = dir_q;
    row_d = row_q;
    if (load) begin
      x_d   = '0;
      y_d   = '0;
      dir_d = cam_ll;
      row_d = cam_ll;
    end else if (adv) begin
      if (x_q != XMAX) begin
        x_d = x_q + CNT_W'(1);
        for (int i = 0; i < 3; i++) dir_d[i] = dir_q[i] + du_q[i];
      end else begin
        x_d = '0;
        y_d = y_q + CNT_W'(1);
        for (int i = 0; i < 3; i++) begin
          row_d[i] = row_q[i] + dv_q[i];
          dir_d[i] = row_d[i];
        end
      end
    end
    last_d = (x_d == XMAX) && (y_d == YMAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      eye_q   <= '0;
      du_q    <= '0;
      dv_q    <= '0;
      dir_q   <= '0;
      row_q   <= '0;
    end else begin
      done_q <= 1'b0;
      x_q    <= x_d;
      y_q    <= y_d;
      dir_q  <= dir_d;
      row_q  <= row_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= EMIT;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            last_q  <= last_d;
            eye_q   <= cam_eye;
            du_q    <= cam_du;
            dv_q    <= cam_dv;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (last_q) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              last_q <= last_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RAYGEN_JITTER_EN
  localparam logic [15:0] SEED = 16'hACE1;

  logic [15:0]      lfsr_q, lfsr_d;
  logic [2:0][31:0] jdir_q, jdir_d, ju, jv;

  // Galois LFSR x^16+x^14+x^13+x^11+1; jitter is applied to the output copy only, never to the accumulators.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load)     lfsr_d = SEED;
    else if (adv) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    for (int i = 0; i < 3; i++) begin
      ju[i]     = 32'($signed(load ? cam_du[i] : du_q[i]) >>> 2);
      jv[i]     = 32'($signed(load ? cam_dv[i] : dv_q[i]) >>> 2);
      jdir_d[i] = dir_d[i] + (lfsr_d[15] ? ju[i] : -ju[i]) + (lfsr_d[14] ? jv[i] : -jv[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
      jdir_q <= '0;
    end else if (load || adv) begin
      lfsr_q <= lfsr_d;
      jdir_q <= jdir_d;
    end
  end

  assign ray_dir = jdir_q;
`else
  assign ray_dir = dir_q;
`endif

  assign ray_valid  = valid_q;
  assign ray_origin = eye_q;
  assign ray_px     = x_q;
  assign ray_py     = y_q;
  assign ray_last   = last_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_ray_gen.sv
// tb_ray_gen: directed bench for ray_gen on a 4x2 frame plus a 1x1 instance for the degenerate size.
module tb_ray_gen;
  localparam int XR = 4;
  localparam int YR = 2;
  localparam int NRAY = XR * YR;
  localparam int unsigned CNT_W = 16;
`ifdef RAYGEN_JITTER_EN
  localparam bit JIT = 1'b1;
`else
  localparam bit JIT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, start, ray_ready;
  logic [2:0][31:0] cam_eye, cam_ll, cam_du, cam_dv;
  logic             ray_valid, ray_last, busy, frame_done;
  logic [2:0][31:0] ray_origin, ray_dir;
  logic [CNT_W-1:0] ray_px, ray_py;
  logic             u1_valid, u1_last, u1_busy, u1_done;
  logic [2:0][31:0] u1_origin, u1_dir;
  logic [CNT_W-1:0] u1_px, u1_py;

  logic [2:0][31:0] m_eye, m_ll, m_du, m_dv;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ray_gen #(.XRES(XR), .YRES(YR), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cam_eye(cam_eye), .cam_ll(cam_ll), .cam_du(cam_du), .cam_dv(cam_dv),
    .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_origin(ray_origin), .ray_dir(ray_dir),
    .ray_px(ray_px), .ray_py(ray_py),
    .ray_last(ray_last), .busy(busy), .frame_done(frame_done)
  );

  ray_gen #(.XRES(1), .YRES(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .reset(reset), .start(start),
    .cam_eye(cam_eye), .cam_ll(cam_ll), .cam_du(cam_du), .cam_dv(cam_dv),
    .ray_valid(u1_valid), .ray_ready(ray_ready),
    .ray_origin(u1_origin), .ray_dir(u1_dir),
    .ray_px(u1_px), .ray_py(u1_py),
    .ray_last(u1_last), .busy(u1_busy), .frame_done(u1_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] lf);
    logic [15:0] n;
    n = lf >> 1;
    if (lf[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Expected direction of ray k: ll + px*du + py*dv, plus quarter-step jitter when enabled.
  function automatic logic [31:0] exp_dir(input int a, input int k, input logic [15:0] lf);
    logic [31:0] d, qu, qv;
    d = m_ll[a];
    for (int i = 0; i < k % XR; i++) d = d + m_du[a];
    for (int j = 0; j < k / XR; j++) d = d + m_dv[a];
    qu = 32'($signed(m_du[a]) >>> 2);
    qv = 32'($signed(m_dv[a]) >>> 2);
    if (JIT) d = d + (lf[15] ? qu : -qu) + (lf[14] ? qv : -qv);
    return d;
  endfunction

  task automatic drive_cam();
    cam_eye = m_eye;
    cam_ll  = m_ll;
    cam_du  = m_du;
    cam_dv  = m_dv;
  endtask

  // mode 0: ready held high; 1: ready toggles; 2: start and camera inputs disturbed mid-frame.
  task automatic run_frame(input int mode);
    int k, cyc;
    bit rdy, done;
    logic [15:0] lf;
    k = 0; cyc = 0; done = 1'b0; lf = 16'hACE1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_on", 64'(busy), 64'd1);
    check("u1_valid", 64'(u1_valid), 64'd1);
    check("u1_last", 64'(u1_last), 64'd1);
    while (!done && cyc < 100) begin
      cyc++;
      if (mode == 2 && k == 3) begin
        start      = 1'b1;
        cam_eye[1] = 32'h0BAD0000;
        cam_ll[0]  = 32'h12345678;
        cam_du[0]  = 32'h00070000;
        cam_dv[1]  = 32'hFFF00000;
      end
      rdy = (mode == 1) ? cyc[0] : 1'b1;
      ray_ready = rdy;
      check("valid", 64'(ray_valid), 64'd1);
      check("px", 64'(ray_px), 64'(k % XR));
      check("py", 64'(ray_py), 64'(k / XR));
      check("dir_x", 64'(ray_dir[0]), 64'(exp_dir(0, k, lf)));
      check("dir_y", 64'(ray_dir[1]), 64'(exp_dir(1, k, lf)));
      check("dir_z", 64'(ray_dir[2]), 64'(exp_dir(2, k, lf)));
      check("origin", 64'({ray_origin[0], ray_origin[1]}), {m_eye[0], m_eye[1]});
      check("last", 64'(ray_last), 64'(k == NRAY - 1));
      @(posedge clk); #1;
      if (rdy) begin
        if (k == NRAY - 1) done = 1'b1;
        else begin
          k++;
          lf = lfsr_step(lf);
        end
      end
    end
    if (!done) check("timeout", 64'd0, 64'd1);
    check("end_valid", 64'(ray_valid), 64'd0);
    check("end_busy", 64'(busy), 64'd0);
    check("frame_done", 64'(frame_done), 64'd1);
    @(posedge clk); #1;
    check("done_pulse", 64'(frame_done), 64'd0);
    check("idle_valid", 64'(ray_valid), 64'd0);
    start = 1'b0;
    ray_ready = 1'b1;
    drive_cam();
    @(posedge clk); #1;
  endtask

  initial begin
    m_eye = '0;
    m_ll[0] = 32'hFFFE0000; m_ll[1] = 32'hFFFF0000; m_ll[2] = 32'hFFFF0000;
    m_du[0] = 32'h00010000; m_du[1] = 32'h0;        m_du[2] = 32'h0;
    m_dv[0] = 32'h0;        m_dv[1] = 32'h00010000; m_dv[2] = 32'h0;
    drive_cam();
    reset = 1'b1; start = 1'b0; ray_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(ray_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_last", 64'(ray_last), 64'd0);
    check("rst_pxpy", 64'({ray_px, ray_py}), 64'd0);
    check("rst_dir", 64'(ray_dir[0]), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_frame(0);  // basic frame
    run_frame(1);  // backpressure
    run_frame(2);  // start and camera changes while busy

    // Abort after three transfers with a nonzero eye
    m_eye[0] = 32'h00050000; m_eye[1] = 32'hFFFD0000; m_eye[2] = 32'h00018000;
    drive_cam();
    ray_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_px", 64'(ray_px), 64'd3);
    check("pre_rst_origin", 64'(ray_origin[0]), 64'h00050000);
    reset = 1'b1;
    #1;
    check("abort_valid", 64'(ray_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_origin", 64'(ray_origin[0]), 64'd0);
    check("abort_dir", 64'(ray_dir[0]), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", 64'(frame_done), 64'd0);
    end
    run_frame(0);  // restarts at (0,0)

    // Direction wraps at 32 bits: second ray dir.x = 0x80000000
    m_ll[0] = 32'h7FFF0000;
    drive_cam();
    check("wrap_model", 64'(exp_dir(0, 1, 16'h0000) - (JIT ? exp_dir(0, 1, 16'h0000) - 32'h80000000 : 32'h0)), 64'h80000000);
    run_frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
